ball_motion_controller: RTL and testbench

BALL_MOTION_CONTROLLER -- requirements
Module: ball_motion_controller

---
 rtl/ball_pkg.sv | 32 +++
 rtl/frame_tick_gen.sv | 13 +
 rtl/ball_motion_controller.sv | 191 +++++++++++++++++++
 tb/tb_ball_motion_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared state encoding, screen/ball constants and speed clamp for the ball datapath
package ball_pkg;

    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_SCREEN_H   = 480;
    localparam int DEF_BALL_SIZE  = 20;
    localparam int DEF_HIT_ZONE_W = 80;
    localparam int DEF_MIN_SPEED  = 2;
    localparam int DEF_MAX_SPEED  = 12;
    localparam int DEF_VY         = 2;
    localparam int DEF_MAX_MISS   = 3;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        MOVE,
        MISS,
        GAME_OVER
    } ball_state_t;

    function automatic logic [9:0] clamp_speed(input logic [9:0] v,
                                               input logic [9:0] lo,
                                               input logic [9:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle strobe on the last active pixel of each frame
module frame_tick_gen #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    output logic       frame_tick
);

    assign frame_tick = (x_pixel == 10'(SCREEN_W - 1)) && (y_pixel == 10'(SCREEN_H - 1));

endmodule

// File: rtl/ball_motion_controller.sv
// rtl/ball_motion_controller.sv - serve/move/miss FSM and per-frame ball position update
module ball_motion_controller
    import ball_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int BALL_SIZE  = DEF_BALL_SIZE,
    parameter int HIT_ZONE_W = DEF_HIT_ZONE_W,
    parameter int MIN_SPEED  = DEF_MIN_SPEED,
    parameter int MAX_SPEED  = DEF_MAX_SPEED,
    parameter int VY         = DEF_VY,
    parameter int MAX_MISS   = DEF_MAX_MISS
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic       start,
    input  logic       collision_detected,
    input  logic [9:0] estimated_speed,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       is_ball_moving_left,
    output logic       is_hit_area,
    output logic       is_ball_pixel,
    output logic [1:0] miss_count,
    output logic       game_over
);

    localparam logic [9:0] X_MAX    = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] Y_MAX    = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] X_CENTER = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTER = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0] SPD_MIN  = 10'(MIN_SPEED);
    localparam logic [9:0] SPD_MAX  = 10'(MAX_SPEED);
    localparam logic [9:0] VY_MAG   = 10'(VY);

    ball_state_t state, state_next;
    logic [9:0]  speed, speed_next;
    logic [9:0]  pending_speed, pending_speed_next;
    logic        hit_pending, hit_pending_next;
    logic        vy_down, vy_down_next;
    logic [9:0]  ball_x_next, ball_y_next;
    logic        moving_left_next;
    logic [1:0]  miss_count_next;
    logic        game_over_next;

    logic        frame_tick;
    logic        hit_now;
    logic [9:0]  clamped_speed;
    logic [9:0]  x_step;
    logic [10:0] x_sum;
    logic [10:0] y_sum;

    frame_tick_gen #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_frame_tick_gen (
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .frame_tick (frame_tick)
    );

    // A pulse on the tick cycle itself is folded straight into that tick's update.
    assign hit_now       = collision_detected && is_ball_moving_left && (state == MOVE);
    assign clamped_speed = clamp_speed(estimated_speed, SPD_MIN, SPD_MAX);
    assign x_step        = hit_now ? clamped_speed : (hit_pending ? pending_speed : speed);
    assign x_sum         = {1'b0, ball_x} + {1'b0, x_step};
    assign y_sum         = {1'b0, ball_y} + {1'b0, VY_MAG};

    always_comb begin
        state_next         = state;
        ball_x_next        = ball_x;
        ball_y_next        = ball_y;
        moving_left_next   = is_ball_moving_left;
        speed_next         = speed;
        pending_speed_next = pending_speed;
        hit_pending_next   = hit_pending;
        vy_down_next       = vy_down;
        miss_count_next    = miss_count;

        case (state)
            IDLE: begin
                if (start)
                    state_next = SERVE;
            end
            SERVE: begin
                if (frame_tick) begin
                    ball_x_next      = X_CENTER;
                    ball_y_next      = Y_CENTER;
                    moving_left_next = 1'b1;
                    speed_next       = SPD_MIN;
                    vy_down_next     = 1'b1;
                    hit_pending_next = 1'b0;
                    state_next       = MOVE;
                end
            end
            MOVE: begin
                if (hit_now) begin
                    hit_pending_next   = 1'b1;
                    pending_speed_next = clamped_speed;
                end
                if (frame_tick) begin
                    if (vy_down) begin
                        if (y_sum > {1'b0, Y_MAX}) begin
                            ball_y_next  = Y_MAX;
                            vy_down_next = 1'b0;
                        end else begin
                            ball_y_next = y_sum[9:0];
                        end
                    end else if (ball_y < VY_MAG) begin
                        ball_y_next  = '0;
                        vy_down_next = 1'b1;
                    end else begin
                        ball_y_next = ball_y - VY_MAG;
                    end

                    if (hit_now || hit_pending) begin
                        moving_left_next = 1'b0;
                        speed_next       = x_step;
                        ball_x_next      = x_sum[9:0];
                        hit_pending_next = 1'b0;
                    end else if (is_ball_moving_left) begin
                        if (ball_x < speed)
                            state_next = MISS;
                        else
                            ball_x_next = ball_x - speed;
                    end else if (x_sum >= {1'b0, X_MAX}) begin
                        ball_x_next      = X_MAX;
                        moving_left_next = 1'b1;
                    end else begin
                        ball_x_next = x_sum[9:0];
                    end
                end
            end
            MISS: begin
                miss_count_next = miss_count + 2'd1;
                state_next      = (miss_count_next == 2'(MAX_MISS)) ? GAME_OVER : SERVE;
            end
            GAME_OVER: begin
                if (start) begin
                    miss_count_next = '0;
                    state_next      = SERVE;
                end
            end
            default: state_next = IDLE;
        endcase

        game_over_next = (state_next == GAME_OVER);
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            ball_x              <= '0;
            ball_y              <= '0;
            is_ball_moving_left <= 1'b1;
            speed               <= SPD_MIN;
            pending_speed       <= SPD_MIN;
            hit_pending         <= 1'b0;
            vy_down             <= 1'b1;
            miss_count          <= '0;
            game_over           <= 1'b0;
        end else begin
            ball_x              <= ball_x_next;
            ball_y              <= ball_y_next;
            is_ball_moving_left <= moving_left_next;
            speed               <= speed_next;
            pending_speed       <= pending_speed_next;
            hit_pending         <= hit_pending_next;
            vy_down             <= vy_down_next;
            miss_count          <= miss_count_next;
            game_over           <= game_over_next;
        end
    end

    logic [10:0] x_end, y_end;
    assign x_end = {1'b0, ball_x} + 11'(BALL_SIZE);
    assign y_end = {1'b0, ball_y} + 11'(BALL_SIZE);

    assign is_ball_pixel = (x_pixel >= ball_x) && ({1'b0, x_pixel} < x_end) &&
                           (y_pixel >= ball_y) && ({1'b0, y_pixel} < y_end);
    assign is_hit_area   = is_ball_pixel && (ball_x < 10'(HIT_ZONE_W));

endmodule

// File: tb/tb_ball_motion_controller.sv
// tb/tb_ball_motion_controller.sv - directed and randomized checks of ball_motion_controller against a frame-level model
module tb_ball_motion_controller;

    logic       clk_25MHz;
    logic       reset;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       start;
    logic       collision_detected;
    logic [9:0] estimated_speed;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       is_ball_moving_left;
    logic       is_hit_area;
    logic       is_ball_pixel;
    logic [1:0] miss_count;
    logic       game_over;

    ball_motion_controller dut (
        .clk_25MHz           (clk_25MHz),
        .reset               (reset),
        .x_pixel             (x_pixel),
        .y_pixel             (y_pixel),
        .start               (start),
        .collision_detected  (collision_detected),
        .estimated_speed     (estimated_speed),
        .ball_x              (ball_x),
        .ball_y              (ball_y),
        .is_ball_moving_left (is_ball_moving_left),
        .is_hit_area         (is_hit_area),
        .is_ball_pixel       (is_ball_pixel),
        .miss_count          (miss_count),
        .game_over           (game_over)
    );

    initial begin
        clk_25MHz = 1'b0;
        forever #20 clk_25MHz = ~clk_25MHz;
    end

    localparam int M_IDLE = 0, M_SERVE = 1, M_MOVE = 2, M_MISS = 3, M_OVER = 4;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference: positions and speeds as plain integers.
    int m_mode, m_bx, m_by, m_left, m_spd, m_vy, m_pend, m_pspd, m_miss, m_over;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_bx = 0; m_by = 0; m_left = 1; m_spd = 2; m_vy = 2;
        m_pend = 0; m_pspd = 2; m_miss = 0; m_over = 0;
    endtask

    task automatic model_step(input bit tk, input bit coll, input int est, input bit st);
        int ny;
        case (m_mode)
            M_IDLE: if (st) m_mode = M_SERVE;
            M_SERVE: if (tk) begin
                m_bx = 310; m_by = 230; m_left = 1; m_spd = 2; m_vy = 2; m_pend = 0;
                m_mode = M_MOVE;
            end
            M_MOVE: begin
                if (coll && m_left == 1) begin
                    m_pend = 1;
                    m_pspd = (est < 2) ? 2 : ((est > 12) ? 12 : est);
                end
                if (tk) begin
                    ny = m_by + m_vy;
                    if (ny < 0) begin m_by = 0; m_vy = -m_vy; end
                    else if (ny > 460) begin m_by = 460; m_vy = -m_vy; end
                    else m_by = ny;
                    if (m_pend == 1) begin
                        m_left = 0; m_spd = m_pspd; m_bx = m_bx + m_spd; m_pend = 0;
                    end else if (m_left == 1) begin
                        if (m_bx < m_spd) m_mode = M_MISS;
                        else m_bx = m_bx - m_spd;
                    end else if (m_bx + m_spd >= 620) begin
                        m_bx = 620; m_left = 1;
                    end else begin
                        m_bx = m_bx + m_spd;
                    end
                end
            end
            M_MISS: begin
                m_miss = m_miss + 1;
                m_mode = (m_miss == 3) ? M_OVER : M_SERVE;
            end
            default: if (st) begin m_miss = 0; m_mode = M_SERVE; end
        endcase
        m_over = (m_mode == M_OVER) ? 1 : 0;
    endtask

    task automatic check_regs();
        check("ball_x", int'(ball_x), m_bx);
        check("ball_y", int'(ball_y), m_by);
        check("moving_left", int'(is_ball_moving_left), m_left);
        check("miss_count", int'(miss_count), m_miss);
        check("game_over", int'(game_over), m_over);
    endtask

    task automatic run_cycle(input bit coll, input int est, input bit st, input int px, input int py);
        bit tk;
        int exp_pix;
        @(negedge clk_25MHz);
        x_pixel = 10'(px);
        y_pixel = 10'(py);
        collision_detected = coll;
        estimated_speed = 10'(est);
        start = st;
        #1;
        exp_pix = (px >= m_bx && px < m_bx + 20 && py >= m_by && py < m_by + 20) ? 1 : 0;
        check("ball_pixel", int'(is_ball_pixel), exp_pix);
        check("hit_area", int'(is_hit_area), (exp_pix == 1 && m_bx < 80) ? 1 : 0);
        tk = (px == 639 && py == 479);
        @(posedge clk_25MHz);
        model_step(tk, coll, est, st);
        #1;
        check_regs();
    endtask

    task automatic tick_cycle(input bit coll, input int est, input bit st);
        run_cycle(coll, est, st, 639, 479);
    endtask

    task automatic near_cycle(input bit coll, input int est, input bit st);
        int px, py;
        px = m_bx + int'($urandom_range(0, 40)) - 10;
        py = m_by + int'($urandom_range(0, 40)) - 10;
        px = (px < 0) ? 0 : ((px > 639) ? 639 : px);
        py = (py < 0) ? 0 : ((py > 479) ? 479 : py);
        run_cycle(coll, est, st, px, py);
    endtask

    task automatic do_reset();
        @(negedge clk_25MHz);
        reset = 1'b1;
        model_reset();
        @(negedge clk_25MHz);
        reset = 1'b0;
    endtask

    task automatic ticks_until_miss(input int target);
        int n = 0;
        while (m_miss < target && n < 1000) begin
            tick_cycle(1'b0, 0, 1'b0);
            n++;
        end
        check("miss_budget", (n < 1000) ? 1 : 0, 1);
    endtask

    initial begin
        int n, bx_before;
        bit coll, st;
        reset = 1'b1;
        x_pixel = '0; y_pixel = '0; start = 1'b0;
        collision_detected = 1'b0; estimated_speed = '0;
        model_reset();
        repeat (2) @(negedge clk_25MHz);
        check("rst_x", int'(ball_x), 0);
        check("rst_y", int'(ball_y), 0);
        check("rst_left", int'(is_ball_moving_left), 1);
        check("rst_miss", int'(miss_count), 0);
        check("rst_over", int'(game_over), 0);
        reset = 1'b0;

        // serve and first frames
        near_cycle(1'b0, 0, 1'b1);
        near_cycle(1'b0, 0, 1'b0);
        tick_cycle(1'b0, 0, 1'b0);
        check("serve_x", int'(ball_x), 310);
        check("serve_y", int'(ball_y), 230);
        tick_cycle(1'b0, 0, 1'b0);
        check("frame2_x", int'(ball_x), 308);
        check("frame2_y", int'(ball_y), 232);

        // fast hit clamps to max speed
        near_cycle(1'b1, 30, 1'b0);
        near_cycle(1'b0, 0, 1'b0);
        tick_cycle(1'b0, 0, 1'b0);
        check("hit_dir", int'(is_ball_moving_left), 0);
        check("hit_x", int'(ball_x), 320);
        tick_cycle(1'b0, 0, 1'b0);
        check("speed12_x", int'(ball_x), 332);

        // pulses while moving right are ignored
        near_cycle(1'b1, 7, 1'b0);
        n = 0;
        while (m_left == 0 && n < 200) begin tick_cycle(1'b0, 0, 1'b0); n++; end
        check("right_wall_x", int'(ball_x), 620);
        check("right_wall_left", int'(is_ball_moving_left), 1);

        // coincident pulse applies on the same tick
        bx_before = m_bx;
        tick_cycle(1'b1, 5, 1'b0);
        check("coincident_x", int'(ball_x), bx_before + 5);
        check("coincident_dir", int'(is_ball_moving_left), 0);

        // three misses end the game, start clears the count
        do_reset();
        near_cycle(1'b0, 0, 1'b1);
        ticks_until_miss(1);
        check("miss1_count", int'(miss_count), 1);
        tick_cycle(1'b0, 0, 1'b0);
        check("reserve_x", int'(ball_x), 310);
        ticks_until_miss(2);
        ticks_until_miss(3);
        check("over_flag", int'(game_over), 1);
        near_cycle(1'b0, 0, 1'b1);
        check("restart_miss", int'(miss_count), 0);
        check("restart_over", int'(game_over), 0);
        tick_cycle(1'b0, 0, 1'b0);
        check("restart_x", int'(ball_x), 310);

        // asynchronous reset mid-flight
        near_cycle(1'b1, 12, 1'b0);
        n = 0;
        while (m_bx < 400 && n < 200) begin tick_cycle(1'b0, 0, 1'b0); n++; end
        check("reach_400", (m_bx >= 400) ? 1 : 0, 1);
        @(negedge clk_25MHz);
        #5 reset = 1'b1;
        #1;
        check("arst_x", int'(ball_x), 0);
        check("arst_y", int'(ball_y), 0);
        check("arst_left", int'(is_ball_moving_left), 1);
        check("arst_miss", int'(miss_count), 0);
        check("arst_over", int'(game_over), 0);
        model_reset();
        @(negedge clk_25MHz);
        reset = 1'b0;

        // randomized play
        for (int i = 0; i < 5000; i++) begin
            coll = ($urandom_range(0, 5) == 0);
            st   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) < 30)
                tick_cycle(coll, int'($urandom_range(0, 40)), st);
            else
                near_cycle(coll, int'($urandom_range(0, 40)), st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
